// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the instruction fetch path (read-only) and
// the data path (read/write). One request is latched at a time. The RAM strobes are
// driven from registers, and completion is signalled with a one-cycle done pulse. A
// watchdog aborts any access that the RAM never acknowledges.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: when both requesters are pending, the one that
// was not granted last wins. Without it, data always has priority over instruction.
module mem_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [DATA_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              idone,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              ddone,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [DATA_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic              err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ramren;
  logic              r_ramwen;
  logic [DATA_W-1:0] r_ramaddr;
  logic [DATA_W-1:0] r_ramstore;
  logic [DATA_W-1:0] r_iload;
  logic [DATA_W-1:0] r_dload;
  logic              r_idone;
  logic              r_ddone;
  logic              r_err;

  logic w_dreq;
  logic w_grant_d;
  logic w_grant_i;
  logic w_timeout;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Requester of the most recently completed access: 0 = instruction, 1 = data.
  logic r_last_grant;
`endif

  // Grant decision in IDLE and watchdog expiry during an access.
  always_comb begin
    w_dreq    = dREN | dWEN;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    w_grant_d = w_dreq & (~iREN | ~r_last_grant);
`else
    w_grant_d = w_dreq;
`endif
    w_grant_i = iREN & ~w_grant_d;
    // Abort on the last permitted cycle if the RAM still has not answered.
    w_timeout = ~ramready & (r_cnt == CNT_LAST);
  end

  // Access sequencer: latch request, hold strobes, capture load, pulse done/err.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ramren   <= 1'b0;
      r_ramwen   <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
      r_iload    <= '0;
      r_dload    <= '0;
      r_idone    <= 1'b0;
      r_ddone    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_idone <= 1'b0;
      r_ddone <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_ramaddr  <= daddr;
            r_ramstore <= dstore;
            // A simultaneous read and write request is treated as a write.
            r_ramwen   <= dWEN;
            r_ramren   <= ~dWEN;
            r_cnt      <= '0;
            r_state    <= DACC;
          end else if (w_grant_i) begin
            r_ramaddr  <= iaddr;
            r_ramstore <= '0;
            r_ramwen   <= 1'b0;
            r_ramren   <= 1'b1;
            r_cnt      <= '0;
            r_state    <= IACC;
          end
        end
        IACC, DACC: begin
          if (ramready) begin
            if (r_state == IACC) begin
              r_iload <= ramload;
            end else if (r_ramren) begin
              r_dload <= ramload;
            end
            r_ramren <= 1'b0;
            r_ramwen <= 1'b0;
            r_idone  <= (r_state == IACC);
            r_ddone  <= (r_state == DACC);
            r_state  <= RESP;
          end else if (w_timeout) begin
            // Done still pulses so the requester is released.
            r_ramren <= 1'b0;
            r_ramwen <= 1'b0;
            r_err    <= 1'b1;
            r_idone  <= (r_state == IACC);
            r_ddone  <= (r_state == DACC);
            r_state  <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember who finished last so a tie goes to the other requester next time.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_last_grant <= 1'b0;
    end else if (((r_state == IACC) || (r_state == DACC)) && (ramready || w_timeout)) begin
      r_last_grant <= (r_state == DACC);
    end
  end
`endif

  assign ramREN   = r_ramren;
  assign ramWEN   = r_ramwen;
  assign ramaddr  = r_ramaddr;
  assign ramstore = r_ramstore;
  assign iload    = r_iload;
  assign dload    = r_dload;
  assign idone    = r_idone;
  assign ddone    = r_ddone;
  assign err      = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. The stimulus predicts the grant order and the results
// of each access from the arbitration rules and pushes them into a queue. A monitor
// process models the RAM (latency per access, backing store) and compares every done pulse.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned CW = 3;

  logic          CLK;
  logic          nRST;
  logic          iREN;
  logic [DW-1:0] iaddr;
  logic [DW-1:0] iload;
  logic          idone;
  logic          dREN;
  logic          dWEN;
  logic [DW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic [DW-1:0] dload;
  logic          ddone;
  logic          ramREN;
  logic          ramWEN;
  logic [DW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic          ramready;
  logic          err;

  mem_arbiter #(.DATA_W(DW), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .idone(idone),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .ddone(ddone),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .err(err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] store;
    logic        ren;
    logic        wen;
    int          lat;   // ramready on this access cycle; 0 = never answer
  } req_t;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] store;
    int          cycles;
    logic        err;
    logic [31:0] iload;
    logic [31:0] dload;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] store;
    int          cycles;
    logic        stable;
  } acc_t;

  req_t d_req_q[$];
  req_t i_req_q[$];
  exp_t exp_q[$];
  int   lat_q[$];
  acc_t acc_q[$];

  logic [31:0] ram_mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] m_iload;
  logic [31:0] m_dload;
  logic        m_last;   // 0 = instruction, 1 = data

  int n_checks = 0;
  int n_fail   = 0;

  int   mcnt;
  int   cur_lat;
  acc_t rec;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic int idx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: one granted access, in grant order.
  task automatic model_access(input req_t r, input logic is_d);
    exp_t e;
    e.is_d   = is_d;
    e.addr   = r.addr;
    e.wen    = is_d & r.wen;
    e.store  = r.store;
    e.err    = (r.lat == 0);
    e.cycles = e.err ? int'(MW) : r.lat;
    lat_q.push_back(r.lat);
    if (!e.err) begin
      if (e.wen) ref_mem[idx(r.addr)] = r.store;
      else if (is_d) m_dload = ref_mem[idx(r.addr)];
      else m_iload = ref_mem[idx(r.addr)];
    end
    e.iload = m_iload;
    e.dload = m_dload;
    exp_q.push_back(e);
  endtask

  task automatic run_d();
    req_t r;
    bit   got;
    while (d_req_q.size() > 0) begin
      r      = d_req_q.pop_front();
      dREN   = r.ren;
      dWEN   = r.wen;
      daddr  = r.addr;
      dstore = r.store;
      got    = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge CLK);
        if (ddone === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      chk("ddone_seen", 32'(got), 32'd1);
      @(posedge CLK);
      #1;
    end
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  task automatic run_i();
    req_t r;
    bit   got;
    while (i_req_q.size() > 0) begin
      r     = i_req_q.pop_front();
      iREN  = 1'b1;
      iaddr = r.addr;
      got   = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge CLK);
        if (idone === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      chk("idone_seen", 32'(got), 32'd1);
      @(posedge CLK);
      #1;
    end
    iREN = 1'b0;
  endtask

  // Predict the grant order of the queued requests, then drive both requesters.
  task automatic run_phase();
    int   nd = d_req_q.size();
    int   ni = i_req_q.size();
    int   di = 0;
    int   ii = 0;
    logic pick_d;
    while ((di < nd) || (ii < ni)) begin
      if ((di < nd) && (ii < ni)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_d = (m_last == 1'b0);
`else
        pick_d = 1'b1;
`endif
      end else begin
        pick_d = (di < nd);
      end
      if (pick_d) begin
        model_access(d_req_q[di], 1'b1);
        di++;
      end else begin
        model_access(i_req_q[ii], 1'b0);
        ii++;
      end
      m_last = pick_d;
    end
    @(posedge CLK);
    #1;
    fork
      run_d();
      run_i();
    join
    repeat (2) @(posedge CLK);
    #1;
  endtask

  function automatic req_t mk_req(input logic [31:0] a, input logic [31:0] s, input logic ren,
                                  input logic wen, input int lat);
    req_t r;
    r.addr = a; r.store = s; r.ren = ren; r.wen = wen; r.lat = lat;
    return r;
  endfunction

  function automatic int rnd_lat();
    if ($urandom_range(0, 5) == 0) return 0;
    return int'($urandom_range(1, MW));
  endfunction

  // RAM model and response monitor.
  initial begin
    ramready = 1'b0;
    ramload  = '0;
    mcnt     = 0;
    cur_lat  = 1;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        mcnt     = 0;
        ramready = 1'b0;
      end else begin
        if (ramREN || ramWEN) begin
          if (mcnt == 0) begin
            if (lat_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_access actual=%0h required=no_access", ramaddr);
              cur_lat = 1;
            end else begin
              cur_lat = lat_q.pop_front();
            end
            rec.addr   = ramaddr;
            rec.ren    = ramREN;
            rec.wen    = ramWEN;
            rec.store  = ramstore;
            rec.stable = 1'b1;
          end else if (ramaddr !== rec.addr || ramREN !== rec.ren || ramWEN !== rec.wen ||
                       ramstore !== rec.store) begin
            rec.stable = 1'b0;
          end
          mcnt++;
          if ((cur_lat != 0) && (mcnt == cur_lat)) begin
            ramready = 1'b1;
            ramload  = ramREN ? ram_mem[idx(ramaddr)] : $urandom;
            if (ramWEN) ram_mem[idx(ramaddr)] = ramstore;
          end else begin
            ramready = 1'b0;
            ramload  = $urandom;
          end
        end else begin
          if (mcnt > 0) begin
            rec.cycles = mcnt;
            acc_q.push_back(rec);
            mcnt = 0;
          end
          // Stray ramready outside an access must be ignored.
          ramready = ($urandom_range(0, 3) == 0);
          ramload  = $urandom;
        end
        if (idone || ddone || err) begin
          chk("one_done", 32'(idone) + 32'(ddone), 32'd1);
        end
        if (idone || ddone) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done actual=i%0b_d%0b required=none", idone, ddone);
          end else if (acc_q.size() == 0) begin
            void'(exp_q.pop_front());
            n_checks++;
            n_fail++;
            $display("FAIL missing_access actual=none required=access");
          end else begin
            exp_t e;
            acc_t a;
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            chk("grant_is_d", 32'(ddone), 32'(e.is_d));
            chk("ram_addr", a.addr, e.addr);
            chk("ram_wen", 32'(a.wen), 32'(e.wen));
            chk("ram_ren", 32'(a.ren), 32'(!e.wen));
            if (e.wen) chk("ram_store", a.store, e.store);
            chk("strobe_cycles", 32'(a.cycles), 32'(e.cycles));
            chk("strobe_stable", 32'(a.stable), 32'd1);
            chk("err", 32'(err), 32'(e.err));
            chk("iload", iload, e.iload);
            chk("dload", dload, e.dload);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    bit          seen;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    m_iload = '0; m_dload = '0; m_last = 1'b0;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    ram_mem[idx(32'h40)] = 32'h2108_0004;
    ref_mem[idx(32'h40)] = 32'h2108_0004;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_done", 32'(idone) + 32'(ddone) + 32'(err), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(posedge CLK);

    // Single instruction read answered on the 2nd access cycle.
    i_req_q.push_back(mk_req(32'h0000_0040, 32'h0, 1'b1, 1'b0, 2));
    run_phase();

    // Simultaneous data and instruction requests.
    d_req_q.push_back(mk_req(32'h0000_0100, $urandom, 1'b1, 1'b0, 1));
    d_req_q.push_back(mk_req(32'h0000_0104, $urandom, 1'b1, 1'b0, 3));
    i_req_q.push_back(mk_req(32'h0000_0044, 32'h0, 1'b1, 1'b0, 1));
    run_phase();

    // Data write answered on the 1st cycle; dload must stay unchanged.
    d_req_q.push_back(mk_req(32'h0000_0200, 32'hDEAD_BEEF, 1'b0, 1'b1, 1));
    run_phase();

    // Read-after-write, then read+write treated as write.
    d_req_q.push_back(mk_req(32'h0000_0200, $urandom, 1'b1, 1'b0, MW));
    d_req_q.push_back(mk_req(32'h0000_0208, 32'h1234_5678, 1'b1, 1'b1, 2));
    run_phase();

    // Watchdog: never answered.
    d_req_q.push_back(mk_req(32'h0000_0300, $urandom, 1'b1, 1'b0, 0));
    run_phase();
    i_req_q.push_back(mk_req(32'h0000_0304, 32'h0, 1'b1, 1'b0, 0));
    run_phase();

    // Continuous requests from both sides, then data only.
    for (int k = 0; k < 2; k++) begin
      d_req_q.push_back(mk_req($urandom, $urandom, 1'b1, 1'b0, 1));
      i_req_q.push_back(mk_req($urandom, 32'h0, 1'b1, 1'b0, 1));
    end
    run_phase();
    for (int k = 0; k < 3; k++) d_req_q.push_back(mk_req($urandom, $urandom, 1'b1, 1'b0, 1));
    run_phase();

    // Reset in the middle of a data write.
    dWEN = 1'b1; dREN = 1'b0; daddr = 32'h0000_0310; dstore = $urandom;
    lat_q.push_back(0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (ramWEN === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("midrst_strobe_seen", 32'(seen), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("midrst_ramWEN", 32'(ramWEN), 32'd0);
    chk("midrst_ramREN", 32'(ramREN), 32'd0);
    chk("midrst_ramaddr", ramaddr, 32'd0);
    chk("midrst_dload", dload, 32'd0);
    chk("midrst_iload", iload, 32'd0);
    chk("midrst_done_err", 32'(ddone) + 32'(idone) + 32'(err), 32'd0);
    m_iload = '0; m_dload = '0; m_last = 1'b0;
    dWEN = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("midrst_no_done", 32'(ddone) + 32'(err), 32'd0);
    end
    nRST = 1'b1;
    repeat (2) @(posedge CLK);

    // Randomized phases.
    for (int p = 0; p < 40; p++) begin
      int kind = int'($urandom_range(0, 2));
      int nd = (kind == 1) ? 0 : int'($urandom_range(1, 3));
      int ni = (kind == 0) ? 0 : int'($urandom_range(1, 3));
      for (int k = 0; k < nd; k++) begin
        int t = int'($urandom_range(0, 2));
        d_req_q.push_back(mk_req($urandom, $urandom, (t != 1), (t != 0), rnd_lat()));
      end
      for (int k = 0; k < ni; k++) begin
        i_req_q.push_back(mk_req($urandom, 32'h0, 1'b1, 1'b0, rnd_lat()));
      end
      run_phase();
    end

    repeat (3) @(posedge CLK);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("lat_q_drained", 32'(lat_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single RAM port and shares it between the instruction fetch path (read-only) and the data path (read/write).
- Sits between the fetch/memory pipeline stages and the RAM.
- Latches one request at a time, drives the RAM strobes from internal registers, and returns the load word with a one-cycle done pulse.
- Includes a watchdog that aborts accesses the RAM never acknowledges.

Parameters:
- DATA_W, 32: width of address, store and load words.
- MAX_WAIT, 255: maximum number of cycles to wait for ramready before aborting.
- CNT_W, 8: width of the watchdog counter. Must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request; held until idone.
- iaddr  in  DATA_W  instruction address.
- iload  out  DATA_W  instruction word returned.
- idone  out  1  one-cycle completion pulse for the instruction request.
- dREN  in  1  data read request; held until ddone.
- dWEN  in  1  data write request; held until ddone.
- daddr  in  DATA_W  data address.
- dstore  in  DATA_W  data store word.
- dload  out  DATA_W  data load word returned.
- ddone  out  1  one-cycle completion pulse for the data request.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  DATA_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data; valid when ramready=1.
- ramready  in  1  RAM completion; may be high for one or more cycles.
- err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- States: IDLE, IACC, DACC, RESP.
- Reset (asynchronous, nRST=0):
  - state goes to IDLE.
  - All outputs go to 0: iload, dload, idone, ddone, ramREN, ramWEN, ramaddr, ramstore, err, and the watchdog counter.
  - Reset mid-access drops the RAM strobes immediately, with no completion pulse.
- IDLE:
  - If dREN or dWEN is high: latch daddr/dstore, go to DACC.
  - Else if iREN is high: latch iaddr, go to IACC.
  - Else stay in IDLE.
  - Default priority: data over instruction.
  - If dREN and dWEN are both high, treat the request as a write.
- IACC/DACC:
  - ramaddr, ramstore, ramREN and ramWEN are driven from registers only.
  - The requester's ports are not sampled again during the access.
  - The watchdog counter clears on entry and increments each cycle ramready is 0.
  - ramready=1: capture ramload into iload or dload (reads only; a write leaves dload unchanged), drop the strobes, go to RESP.
  - Counter reaches MAX_WAIT with ramready still 0: drop the strobes, pulse err for one cycle, go to RESP. The load register is unchanged, and done still pulses so the requester is not hung.
- RESP:
  - The matching idone or ddone is high for exactly this cycle.
  - Next state is IDLE unconditionally.
  - Requests are ignored in RESP; the requester deasserts in the cycle after done.
- Latency:
  - Request seen in IDLE at cycle N → strobe asserted in N+1.
  - ramready at cycle M → done at M+1 → IDLE at M+2.
  - Minimum round trip with zero-wait RAM: 3 cycles.
- ramready while in IDLE or RESP is ignored.
- iload and dload hold their value until the next completed read for that requester.
- At most one of idone, ddone is high in any cycle.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- When defined:
  - A one-bit last_grant register (reset value: instruction) records the requester of the most recently completed access.
  - When both requests are pending in IDLE, the requester that was not last granted wins.
  - A single pending request still wins immediately.
- When not defined: fixed data-over-instruction priority, and no last_grant register is present.

Test Plan:
- Reset mid-access: nRST low in DACC with ramWEN=1 → ramWEN=0 in the same cycle, state IDLE, no ddone, no err.
- Single instruction read: iREN=1, iaddr=0x0000_0040, ramready at the 2nd access cycle with ramload=0x2108_0004 → ramREN=1 with ramaddr=0x40 for 2 cycles, then idone=1 with iload=0x2108_0004 in the next cycle.
- Simultaneous requests, macro off: iREN and dREN both 1 with daddr=0x100, both held for 3 accesses → data granted first, then instruction.
- Data write, ramready on the 1st access cycle: dWEN=1, daddr=0x200, dstore=0xDEAD_BEEF → ramWEN=1 with ramstore=0xDEAD_BEEF for 1 cycle, ddone the next cycle, dload unchanged.
- Watchdog: MAX_WAIT=4, dREN=1, ramready held at 0 → strobe high for 4 cycles, then err=1 and ddone=1 together in RESP, dload unchanged.
- Macro on: continuous iREN and dREN for 4 grants → order D, I, D, I. With dREN only → consecutive D grants.
